// File: rtl/pixel_output_queue.sv
// Transmit-side pixel FIFO between a rasterizer core and the depth comparator.
// Head entry is presented on data_out/data_write and retired on output_written.
package pixel_output_queue_pkg;
    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] depth;
        logic [23:0] color;
    } pixel_info_t;
endpackage

module pixel_output_queue
    import pixel_output_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       switch_buffer,
    input  pixel_info_t                in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output pixel_info_t                data_out,
    output logic                       data_write,
    input  logic                       output_written,
    output logic                       drained,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       spurious_error
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count_nxt;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    pixel_info_t     mem [DEPTH];
    logic            push, pop, spurious;

    // All handshake outputs come straight from registered state.
    assign in_ready   = (state != FULL);
    assign data_write = (state != EMPTY);
    assign drained    = (state == EMPTY);
    assign data_out   = data_write ? mem[rd_ptr] : '0;

    // A flush cycle swallows any coincident push, pop or spurious write.
    assign push     = in_valid && in_ready && !switch_buffer;
    assign pop      = output_written && data_write && !switch_buffer;
    assign spurious = output_written && !data_write && !switch_buffer;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (switch_buffer) begin
            state_nxt = EMPTY;
            count_nxt = '0;
        end else begin
            if (push && !pop) count_nxt = count + CW'(1);
            if (pop && !push) count_nxt = count - CW'(1);
            case (state)
                EMPTY:   if (push) state_nxt = ACTIVE;
                ACTIVE: begin
                    if (pop && !push && count == CW'(1))
                        state_nxt = EMPTY;
                    else if (push && !pop && count == CW'(DEPTH-1))
                        state_nxt = FULL;
                end
                FULL:    if (pop) state_nxt = ACTIVE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= EMPTY;
            count          <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            spurious_error <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (spurious) spurious_error <= 1'b1;
            if (switch_buffer) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: data_out is masked while the queue is empty.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_pixel_output_queue.sv
// Directed bench for pixel_output_queue (DEPTH=4) with immediate-assertion checks.
module tb_pixel_output_queue;
    import pixel_output_queue_pkg::*;

    logic        clock = 1'b0;
    logic        reset, switch_buffer, in_valid, in_ready;
    logic        data_write, output_written, drained, spurious_error;
    pixel_info_t in_data, data_out;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    pixel_output_queue #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset), .switch_buffer(switch_buffer),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .data_out(data_out), .data_write(data_write),
        .output_written(output_written), .drained(drained),
        .count(count), .spurious_error(spurious_error)
    );

    always #5 clock = ~clock;

    function automatic pixel_info_t px(input logic [7:0] v);
        px = '0;
        px.color[7:0] = v;
        px.x[7:0]     = ~v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [7:0] v, input logic [2:0] n);
        chk({tag, ".data_out"}, 64'(data_out), 64'(px(v)));
        chk({tag, ".count"}, 64'(count), 64'(n));
        chk({tag, ".data_write"}, 64'(data_write), 64'(1));
    endtask

    initial begin
        reset = 1'b1; switch_buffer = 1'b0; in_valid = 1'b0;
        in_data = '0; output_written = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst.count", 64'(count), 0);
        chk("rst.data_write", 64'(data_write), 0);
        chk("rst.data_out", 64'(data_out), 0);
        chk("rst.in_ready", 64'(in_ready), 1);
        chk("rst.drained", 64'(drained), 1);
        chk("rst.spurious", 64'(spurious_error), 0);

        // Single entry, held while the comparator is busy
        in_valid = 1'b1; in_data = px(8'h11);
        tick();
        in_valid = 1'b0;
        chk_head("push1", 8'h11, 3'd1);
        chk("push1.drained", 64'(drained), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold.data_out", 64'(data_out), 64'(px(8'h11)));
        end
        output_written = 1'b1;
        tick();
        output_written = 1'b0;
        chk("pop1.data_write", 64'(data_write), 0);
        chk("pop1.drained", 64'(drained), 1);
        chk("pop1.count", 64'(count), 0);

        // Fill to DEPTH, then an extra in_valid that must be ignored
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = px(8'h21 + 8'(i));
            tick();
        end
        chk("full.count", 64'(count), 4);
        chk("full.in_ready", 64'(in_ready), 0);
        in_data = px(8'h25);
        tick();
        in_valid = 1'b0;
        chk_head("full.ignore", 8'h21, 3'd4);
        output_written = 1'b1;
        tick();
        chk("popfull.in_ready", 64'(in_ready), 1);
        chk_head("popfull", 8'h22, 3'd3);
        tick();
        chk_head("pop2", 8'h23, 3'd2);

        // Streaming push+pop at count=2; pointers wrap several times
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = px(8'h31 + 8'(i));
            tick();
            chk_head("stream", (i == 0) ? 8'h24 : 8'h31 + 8'(i - 1), 3'd2);
        end
        output_written = 1'b0;
        in_data = px(8'h37);
        tick();
        in_valid = 1'b0;
        chk_head("pre_flush", 8'h35, 3'd3);

        // Flush with coincident push and output_written
        switch_buffer = 1'b1; in_valid = 1'b1; in_data = px(8'h38); output_written = 1'b1;
        tick();
        switch_buffer = 1'b0; in_valid = 1'b0; output_written = 1'b0;
        chk("flush.count", 64'(count), 0);
        chk("flush.data_write", 64'(data_write), 0);
        chk("flush.drained", 64'(drained), 1);
        chk("flush.in_ready", 64'(in_ready), 1);
        chk("flush.spurious", 64'(spurious_error), 0);

        // output_written on an empty queue during a flush is not spurious
        switch_buffer = 1'b1; output_written = 1'b1;
        tick();
        switch_buffer = 1'b0; output_written = 1'b0;
        chk("flush_ow.spurious", 64'(spurious_error), 0);

        // Spurious write on an empty queue
        output_written = 1'b1;
        tick();
        output_written = 1'b0;
        chk("spur.flag", 64'(spurious_error), 1);
        chk("spur.count", 64'(count), 0);
        switch_buffer = 1'b1;
        tick();
        switch_buffer = 1'b0;
        chk("spur.sticky", 64'(spurious_error), 1);

        // Queue usable after flush, then reset clears everything
        in_valid = 1'b1; in_data = px(8'h41);
        tick();
        in_valid = 1'b0;
        chk_head("post_flush", 8'h41, 3'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2.spurious", 64'(spurious_error), 0);
        chk("rst2.count", 64'(count), 0);
        chk("rst2.data_write", 64'(data_write), 0);
        chk("rst2.data_out", 64'(data_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
